// File: rtl/gray_to_binary_decoder.sv
// Purpose: synchronise a Gray-coded count and register its binary decode, increment, wrap and step-error flags.
// Latency: a gray_in value stable before edge N is on binary_out (with its pulses) after edge N+SYNC_STAGES.
// Backpressure: none; every accepted change produces a single-cycle bin_valid pulse.
module gray_to_binary_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] binary_out,
  output logic             bin_valid,
  output logic [WIDTH-1:0] delta,
  output logic             wrap,
  output logic             step_err,
  output logic             err_sticky
);

  // Fill counter must be able to hold the value SYNC_STAGES.
  localparam int FILL_W = (SYNC_STAGES < 1) ? 1 : $clog2(SYNC_STAGES + 1);

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  g_s;
  logic [WIDTH-1:0]  bin_new;
  logic [WIDTH-1:0]  g_diff;

  state_t            state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WIDTH-1:0]  g_prev_q, g_prev_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [WIDTH-1:0]  delta_q, delta_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic              step_err_q, step_err_d;
  logic              err_sticky_q, err_sticky_d;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain register chain on the asynchronous Gray input; no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g_s     = sync_q[SYNC_STAGES-1];
  assign bin_new = gray2bin(g_s);
  assign g_diff  = g_s ^ g_prev_q;

  // Next-state: INIT waits until the sync chain holds a real post-reset sample,
  // loads it silently, then TRACK reports every change of the synchronised value.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    g_prev_d   = g_prev_q;
    bin_d      = bin_q;
    valid_d    = 1'b0;
    delta_d    = '0;
    wrap_d     = 1'b0;
    step_err_d = 1'b0;
    case (state_q)
      INIT: begin
        if (fill_q == FILL_W'(SYNC_STAGES)) begin
          g_prev_d = g_s;
          bin_d    = bin_new;
          state_d  = TRACK;
        end else begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
      TRACK: begin
        if (g_diff != '0) begin
          g_prev_d   = g_s;
          bin_d      = bin_new;
          valid_d    = 1'b1;
          delta_d    = bin_new - bin_q;
          wrap_d     = (&bin_q) && (bin_new == '0);
          // More than one bit set in the difference means an illegal Gray step.
          step_err_d = |(g_diff & (g_diff - WIDTH'(1)));
        end
      end
      default: state_d = INIT;
    endcase
    // Clear wins over a coincident new error.
    err_sticky_d = (err_sticky_q | step_err_d) & ~err_clr;
  end

  // State, history and all outputs are registered; reset returns everything to zero/INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      fill_q       <= '0;
      g_prev_q     <= '0;
      bin_q        <= '0;
      delta_q      <= '0;
      valid_q      <= 1'b0;
      wrap_q       <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      g_prev_q     <= g_prev_d;
      bin_q        <= bin_d;
      delta_q      <= delta_d;
      valid_q      <= valid_d;
      wrap_q       <= wrap_d;
      step_err_q   <= step_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign binary_out = bin_q;
  assign bin_valid  = valid_q;
  assign delta      = delta_q;
  assign wrap       = wrap_q;
  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_gray_to_binary_decoder.sv
// Purpose: self-checking bench for gray_to_binary_decoder (table vectors, hand sequences, random walk vs model).
// Latency: checks outputs 1 ns after each rising edge; inputs change on falling edges.
// Backpressure: not applicable.
module tb_gray_to_binary_decoder;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] gray_in = 4'b0110;
  logic [W-1:0] binary_out;
  logic         bin_valid;
  logic [W-1:0] delta;
  logic         wrap;
  logic         step_err;
  logic         err_sticky;

  gray_to_binary_decoder #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_in    (gray_in),
    .err_clr    (err_clr),
    .binary_out (binary_out),
    .bin_valid  (bin_valid),
    .delta      (delta),
    .wrap       (wrap),
    .step_err   (step_err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue delays samples by the synchroniser depth; the first
  // sample out of the queue after reset seeds the history silently.
  int mq[$];
  bit m_init;
  int m_gprev, m_bin, m_delta, m_gs, m_nb;
  bit m_valid, m_wrap, m_step, m_sticky;

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = g; s != 0; s = s >> 1) b = b ^ s;
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input int b);
    int g;
    g = b ^ (b >> 1);
    return g[W-1:0];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_init = 1'b0; m_gprev = 0; m_bin = 0; m_delta = 0;
      m_valid = 1'b0; m_wrap = 1'b0; m_step = 1'b0; m_sticky = 1'b0;
    end else begin
      mq.push_back(int'(gray_in));
      m_valid = 1'b0; m_delta = 0; m_wrap = 1'b0; m_step = 1'b0;
      if (mq.size() > S) begin
        m_gs = mq.pop_front();
        m_nb = g2b(m_gs);
        if (!m_init) begin
          m_init = 1'b1; m_gprev = m_gs; m_bin = m_nb;
        end else if (m_gs != m_gprev) begin
          m_valid = 1'b1;
          m_delta = (m_nb - m_bin + 16) % 16;
          m_wrap  = (m_bin == 15) && (m_nb == 0);
          m_step  = $countones(m_gs ^ m_gprev) > 1;
          m_gprev = m_gs;
          m_bin   = m_nb;
        end
      end
      m_sticky = (m_sticky || m_step) && !err_clr;
    end
    #1;
    if (chk_en) begin
      check("mdl_binary_out", int'(binary_out), m_bin);
      check("mdl_bin_valid", int'(bin_valid), int'(m_valid));
      check("mdl_delta", int'(delta), m_delta);
      check("mdl_wrap", int'(wrap), int'(m_wrap));
      check("mdl_step_err", int'(step_err), int'(m_step));
      check("mdl_err_sticky", int'(err_sticky), int'(m_sticky));
    end
  end

  typedef struct {
    logic [W-1:0] g;
    logic         clr;
    logic [W-1:0] bin;
    logic [W-1:0] dlt;
    logic         wrp;
    logic         stp;
    logic         stk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [W-1:0] g, input logic clr, input logic [W-1:0] bin,
                     input logic [W-1:0] dlt, input logic wrp, input logic stp, input logic stk);
    vec_t v;
    v.g = g; v.clr = clr; v.bin = bin; v.dlt = dlt; v.wrp = wrp; v.stp = stp; v.stk = stk;
    tbl.push_back(v);
  endtask

  // Drive one Gray value, check the update cycle, then check the following quiet cycle.
  task automatic apply(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    gray_in = v.g;
    repeat (S) @(negedge clk);
    err_clr = v.clr;
    @(posedge clk); #1;
    check({nm, "_binary_out"}, int'(binary_out), int'(v.bin));
    check({nm, "_bin_valid"}, int'(bin_valid), 1);
    check({nm, "_delta"}, int'(delta), int'(v.dlt));
    check({nm, "_wrap"}, int'(wrap), int'(v.wrp));
    check({nm, "_step_err"}, int'(step_err), int'(v.stp));
    check({nm, "_err_sticky"}, int'(err_sticky), int'(v.stk));
    @(negedge clk);
    err_clr = 1'b0;
    @(posedge clk); #1;
    check({nm, "_hold_valid"}, int'(bin_valid), 0);
    check({nm, "_hold_bin"}, int'(binary_out), int'(v.bin));
    check({nm, "_hold_pulses"}, int'({delta, wrap, step_err}), 0);
    check({nm, "_hold_sticky"}, int'(err_sticky), int'(v.stk));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int cur;
  int r;

  initial begin
    // Count sequence 1..15 then 0, one legal step each.
    add(4'b0001, 0, 4'd1, 4'd1, 0, 0, 0);
    add(4'b0011, 0, 4'd2, 4'd1, 0, 0, 0);
    add(4'b0010, 0, 4'd3, 4'd1, 0, 0, 0);
    add(4'b0110, 0, 4'd4, 4'd1, 0, 0, 0);
    add(4'b0111, 0, 4'd5, 4'd1, 0, 0, 0);
    add(4'b0101, 0, 4'd6, 4'd1, 0, 0, 0);
    add(4'b0100, 0, 4'd7, 4'd1, 0, 0, 0);
    add(4'b1100, 0, 4'd8, 4'd1, 0, 0, 0);
    add(4'b1101, 0, 4'd9, 4'd1, 0, 0, 0);
    add(4'b1111, 0, 4'd10, 4'd1, 0, 0, 0);
    add(4'b1110, 0, 4'd11, 4'd1, 0, 0, 0);
    add(4'b1010, 0, 4'd12, 4'd1, 0, 0, 0);
    add(4'b1011, 0, 4'd13, 4'd1, 0, 0, 0);
    add(4'b1001, 0, 4'd14, 4'd1, 0, 0, 0);
    add(4'b1000, 0, 4'd15, 4'd1, 0, 0, 0);
    add(4'b0000, 0, 4'd0, 4'd1, 1, 0, 0);
    // Illegal jump 1 -> 5, backward steps, clear-vs-error priority.
    add(4'b0001, 0, 4'd1, 4'd1, 0, 0, 0);
    add(4'b0111, 0, 4'd5, 4'd4, 0, 1, 1);
    add(4'b0011, 0, 4'd2, 4'd13, 0, 0, 1);
    add(4'b0001, 0, 4'd1, 4'd15, 0, 0, 1);
    add(4'b0111, 1, 4'd5, 4'd4, 0, 1, 0);
    add(4'b0110, 0, 4'd4, 4'd15, 0, 0, 0);

    // Reset and init with a non-zero Gray value held.
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;
    for (int e = 1; e <= S + 1; e++) begin
      @(posedge clk); #1;
      check($sformatf("init_e%0d_binary_out", e), int'(binary_out), (e == S + 1) ? 4 : 0);
      check($sformatf("init_e%0d_flags", e), int'({bin_valid, step_err, err_sticky, wrap}), 0);
    end
    repeat (2) begin
      @(posedge clk); #1;
      check("init_hold_binary_out", int'(binary_out), 4);
      check("init_hold_valid", int'(bin_valid), 0);
    end

    // Restart from Gray zero for the table.
    @(negedge clk);
    rst_n = 1'b0;
    gray_in = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (S + 2) @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Mid-operation reset with a change in flight.
    @(negedge clk);
    gray_in = 4'b1101;
    repeat (S) @(negedge clk);
    @(posedge clk); #1;
    check("midrst_pre_binary_out", int'(binary_out), 9);
    @(negedge clk);
    gray_in = 4'b1111;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_binary_out", int'(binary_out), 0);
    check("midrst_bin_valid", int'(bin_valid), 0);
    check("midrst_delta", int'(delta), 0);
    check("midrst_wrap", int'(wrap), 0);
    check("midrst_step_err", int'(step_err), 0);
    check("midrst_err_sticky", int'(err_sticky), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= S + 1; e++) begin
      @(posedge clk); #1;
      check($sformatf("postrst_e%0d_binary_out", e), int'(binary_out), (e == S + 1) ? 10 : 0);
      check($sformatf("postrst_e%0d_flags", e), int'({bin_valid, step_err, err_sticky, wrap}), 0);
    end

    // Random walk: mostly +1, some -1, some jumps, some holds, occasional clears.
    cur = 10;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 9);
      if (r <= 5) cur = (cur + 1) % 16;
      else if (r == 6) cur = (cur + 15) % 16;
      else if (r == 7) cur = $urandom_range(0, 15);
      gray_in = b2g(cur);
      err_clr = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    err_clr = 1'b0;
    repeat (S + 3) @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
